// File: rtl/program_rom_loader.sv
// Instruction ROM that a UART byte stream can reload: a 2-byte word count, then little-endian words.
// Registered read with 1-cycle latency; no backpressure, so every strobed byte is consumed or ignored.
module program_rom_loader #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic [31:0]           Instruction,
   input  logic                  upg_mode,
   input  logic                  upg_rx_valid,
   input  logic [7:0]            upg_rx_data,
   output logic                  upg_busy,
   output logic                  upg_done,
   output logic                  upg_err
);

   localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, COLLECT, WRITE, DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wp_q, wp_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [1:0]            bi_q, bi_d;
   logic [31:0]           word_q, word_d;
   logic [7:0]            cnt_lo_q, cnt_lo_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  mode_q, mode_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [31:0]           n_ext;
   logic                  last_word;
   logic                  wr_en;

   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

   assign last_word = (wp_q == last_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (upg_mode) state_d = HDR0;
         // Only a fresh rising edge of upg_mode restarts after a completed download.
         DONE:    if (upg_mode && !mode_q) state_d = HDR0;
         HDR0:    if (!upg_mode) state_d = IDLE; else if (upg_rx_valid) state_d = HDR1;
         HDR1:    if (!upg_mode) state_d = IDLE; else if (upg_rx_valid) state_d = COLLECT;
         COLLECT: if (!upg_mode) state_d = IDLE;
                  else if (upg_rx_valid && bi_q == 2'd3) state_d = WRITE;
         WRITE:   if (last_word) state_d = DONE; else if (!upg_mode) state_d = IDLE;
                  else state_d = COLLECT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      upg_busy    = (state_q == HDR0) || (state_q == HDR1) ||
                    (state_q == COLLECT) || (state_q == WRITE);
      wr_en       = (state_q == WRITE);
      Instruction = (upg_busy || upg_mode) ? 32'h0000_0000 : rdata_q;
      upg_done    = done_q;
      upg_err     = err_q;
   end

   always_comb begin
      wp_d     = wp_q;
      last_d   = last_q;
      bi_d     = bi_q;
      word_d   = word_q;
      cnt_lo_d = cnt_lo_q;
      done_d   = done_q;
      err_d    = err_q;
      mode_d   = upg_mode;
      rdata_d  = mem[fetch_addr];
      n_ext    = {16'd0, upg_rx_data, cnt_lo_q};
      case (state_q)
         HDR0: if (upg_mode && upg_rx_valid) cnt_lo_d = upg_rx_data;
         HDR1: if (upg_mode && upg_rx_valid) begin
            // Zero or oversized counts fill the whole array; last_q holds N-1.
            if (n_ext == 32'd0 || n_ext > DEPTH) last_d = '1;
            else                                 last_d = ADDR_WIDTH'(n_ext - 32'd1);
         end
         COLLECT: if (upg_mode && upg_rx_valid) begin
            word_d[{bi_q, 3'b000} +: 8] = upg_rx_data;
            bi_d = bi_q + 2'd1;
         end
         WRITE: begin
            wp_d = (&wp_q) ? wp_q : wp_q + 1'b1;
            bi_d = 2'd0;
            if (!last_word && upg_mode && upg_rx_valid) begin
               word_d[7:0] = upg_rx_data;
               bi_d = 2'd1;
            end
         end
         default: ;
      endcase
      if ((state_q == IDLE || state_q == DONE) && state_d == HDR0) begin
         wp_d   = '0;
         bi_d   = 2'd0;
         done_d = 1'b0;
         err_d  = 1'b0;
      end
      if (upg_busy && state_d == IDLE) err_d = 1'b1;
      if (state_q == WRITE && state_d == DONE) done_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp_q     <= '0;
         last_q   <= '0;
         bi_q     <= 2'd0;
         word_q   <= 32'd0;
         cnt_lo_q <= 8'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         mode_q   <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         wp_q     <= wp_d;
         last_q   <= last_d;
         bi_q     <= bi_d;
         word_q   <= word_d;
         cnt_lo_q <= cnt_lo_d;
         done_q   <= done_d;
         err_q    <= err_d;
         mode_q   <= mode_d;
         rdata_q  <= rdata_d;
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wp_q] <= word_q;
   end

endmodule

// File: tb/tb_program_rom_loader.sv
// Randomized bench for program_rom_loader with a byte-stream reference model.
module tb_program_rom_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] fetch_addr = '0;
   logic [31:0]   Instruction;
   logic          upg_mode = 1'b0;
   logic          upg_rx_valid = 1'b0;
   logic [7:0]    upg_rx_data = 8'd0;
   logic          upg_busy, upg_done, upg_err;

   int n_checks = 0;
   int n_fail   = 0;

   program_rom_loader #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .fetch_addr(fetch_addr), .Instruction(Instruction),
      .upg_mode(upg_mode), .upg_rx_valid(upg_rx_valid), .upg_rx_data(upg_rx_data),
      .upg_busy(upg_busy), .upg_done(upg_done), .upg_err(upg_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the download as a byte stream and a list of written words.
   logic [31:0] mem_m [DEPTH];
   bit          wr_m  [DEPTH];
   bit          m_active, m_fin, m_done, m_err, m_pend, m_prev_mode, m_rvalid;
   int          m_hdr, m_nb, m_wp, m_n;
   logic [7:0]  m_lo;
   logic [31:0] m_word, m_rdata;
   logic [15:0] m_hn;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_active = 0; m_fin = 0; m_done = 0; m_err = 0; m_pend = 0;
         m_prev_mode = 0; m_rdata = 32'd0; m_rvalid = 1;
      end else begin
         m_rdata  = mem_m[fetch_addr];
         m_rvalid = wr_m[fetch_addr];
         if (!m_active) begin
            if (upg_mode && (!m_fin || !m_prev_mode)) begin
               m_active = 1; m_fin = 0; m_done = 0; m_err = 0;
               m_hdr = 0; m_nb = 0; m_wp = 0; m_pend = 0;
            end
         end else if (m_pend) begin
            mem_m[m_wp] = m_word;
            wr_m[m_wp]  = 1;
            m_wp++;
            m_pend = 0;
            m_nb   = 0;
            if (m_wp == m_n) begin
               m_active = 0; m_fin = 1; m_done = 1;
            end else if (!upg_mode) begin
               m_active = 0; m_err = 1;
            end else if (upg_rx_valid) begin
               m_word[7:0] = upg_rx_data;
               m_nb = 1;
            end
         end else if (!upg_mode) begin
            m_active = 0; m_err = 1;
         end else if (upg_rx_valid) begin
            if (m_hdr == 0) begin
               m_lo = upg_rx_data; m_hdr = 1;
            end else if (m_hdr == 1) begin
               m_hn  = {upg_rx_data, m_lo};
               m_n   = (m_hn == 0 || m_hn > DEPTH) ? DEPTH : int'(m_hn);
               m_hdr = 2;
            end else begin
               m_word[8*m_nb +: 8] = upg_rx_data;
               m_nb++;
               if (m_nb == 4) begin
                  m_pend = 1; m_nb = 0;
               end
            end
         end
         m_prev_mode = upg_mode;
      end
   end

   always @(negedge clock) begin
      chk("busy", {31'd0, upg_busy}, {31'd0, m_active});
      chk("done", {31'd0, upg_done}, {31'd0, m_done});
      chk("err",  {31'd0, upg_err},  {31'd0, m_err});
      if (m_active || upg_mode)
         chk("instr_nop", Instruction, 32'd0);
      else if (m_rvalid)
         chk("instr_read", Instruction, m_rdata);
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      upg_rx_valid = 1'b1;
      upg_rx_data  = b;
      tick();
      upg_rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic rd(input int addr);
      fetch_addr = AW'(addr);
      tick();
   endtask

   task automatic download(input logic [15:0] n, input int abort_at, input int maxgap);
      int         neff;
      int         total;
      logic [7:0] b;
      neff  = (n == 0 || n > DEPTH) ? DEPTH : int'(n);
      total = 2 + 4 * neff;
      upg_mode = 1'b1;
      tick();
      for (int i = 0; i < total; i++) begin
         if (i == abort_at) break;
         b = (i == 0) ? n[7:0] : (i == 1) ? n[15:8] : 8'($urandom);
         send(b, $urandom_range(0, maxgap));
      end
      if (abort_at >= 0 && abort_at < total) begin
         tick();
         upg_mode     = 1'b0;
         upg_rx_valid = 1'($urandom_range(0, 1));
         upg_rx_data  = 8'($urandom);
         tick();
         upg_rx_valid = 1'b0;
         tick();
         chk("abort_err", {31'd0, upg_err}, 32'd1);
      end else begin
         repeat (3) tick();
         chk("dl_done", {31'd0, upg_done}, 32'd1);
         upg_mode = 1'b0;
         tick();
      end
   endtask

   initial begin
      logic [7:0] seq29 [10];
      int         n, neff, ab;
      seq29 = '{8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h00, 8'h00};

      repeat (3) tick();
      chk("rst_busy",  {31'd0, upg_busy}, 32'd0);
      chk("rst_done",  {31'd0, upg_done}, 32'd0);
      chk("rst_err",   {31'd0, upg_err},  32'd0);
      chk("rst_instr", Instruction, 32'd0);
      reset = 1'b0;
      tick();

      // Back-to-back bytes: 0x3C arrives during the WRITE of the first word.
      upg_mode = 1'b1;
      tick();
      foreach (seq29[i]) send(seq29[i], 0);
      repeat (2) tick();
      chk("d29_done", {31'd0, upg_done}, 32'd1);
      chk("d29_err",  {31'd0, upg_err},  32'd0);
      // Still in download mode: bytes must be ignored, no restart.
      send(8'h55, 0); send(8'h66, 1);
      chk("d29_hold", {31'd0, upg_done}, 32'd1);
      upg_mode = 1'b0;
      rd(1);
      chk("d30_addr1", Instruction, 32'h0000_013C);
      rd(0);
      chk("d30_addr0", Instruction, 32'h0500_0820);

      download(16'h0000, -1, 2);
      for (int a = 0; a < DEPTH; a++) rd(a);
      download(16'h0020, -1, 1);
      for (int a = 0; a < DEPTH; a++) rd(a);

      // Abort after 6 data bytes of N=3, with a strobe in the abort cycle.
      upg_mode = 1'b1;
      tick();
      send(8'h03, 0); send(8'h00, 0);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
      send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
      tick();
      upg_mode = 1'b0; upg_rx_valid = 1'b1; upg_rx_data = 8'h77;
      tick();
      upg_rx_valid = 1'b0;
      tick();
      chk("d32_err",  {31'd0, upg_err},  32'd1);
      chk("d32_busy", {31'd0, upg_busy}, 32'd0);
      rd(0);
      chk("d32_mem0", Instruction, 32'h4433_2211);
      rd(1);

      // Reset in the middle of a word.
      upg_mode = 1'b1;
      tick();
      send(8'h04, 0); send(8'h00, 0);
      send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0);
      #1 reset = 1'b1;
      #1;
      chk("d33_busy",  {31'd0, upg_busy}, 32'd0);
      chk("d33_done",  {31'd0, upg_done}, 32'd0);
      chk("d33_err",   {31'd0, upg_err},  32'd0);
      chk("d33_instr", Instruction, 32'd0);
      upg_mode = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      rd(0);
      chk("d33_mem0", Instruction, 32'hDDCC_BBAA);
      upg_mode = 1'b1;
      tick();
      send(8'h01, 0); send(8'h00, 1);
      send(8'h01, 0); send(8'h02, 2); send(8'h03, 0); send(8'h04, 0);
      repeat (2) tick();
      chk("d33_redl", {31'd0, upg_done}, 32'd1);
      upg_mode = 1'b0;
      rd(0);
      chk("d33_wp0", Instruction, 32'h0403_0201);

      for (int r = 0; r < 10; r++) begin
         n    = $urandom_range(0, 40);
         neff = (n == 0 || n > DEPTH) ? DEPTH : n;
         ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 1 + 4 * neff) : -1;
         download(16'(n), ab, 2);
         repeat (6) rd($urandom_range(0, DEPTH - 1));
      end
      for (int a = 0; a < DEPTH; a++) rd(a);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/program_rom_loader.md
PROGRAM_ROM_LOADER -- requirements
Module: program_rom_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 Parameter ADDR_WIDTH, default 14, SHALL set the word-address width; depth = 2^ADDR_WIDTH 32-bit words.
REQ-003 Port clock, input, 1 bit: all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high; asserting it SHALL immediately force the reset state.
REQ-005 Port fetch_addr, input, ADDR_WIDTH bits: word address from the fetch unit (PC[15:2]).
REQ-006 Port Instruction, output, 32 bits: instruction word returned to the fetch unit.
REQ-007 Port upg_mode, input, 1 bit: 1 selects download mode, 0 selects run mode.
REQ-008 Port upg_rx_valid, input, 1 bit: single-cycle strobe marking a received UART byte.
REQ-009 Port upg_rx_data, input, 8 bits: the received byte, sampled when upg_rx_valid=1.
REQ-010 Port upg_busy, output, 1 bit: 1 while a download is in progress (HDR0..WRITE).
REQ-011 Port upg_done, output, 1 bit: 1 once a download has completed; held until the next download starts or reset.
REQ-012 Port upg_err, output, 1 bit: 1 when upg_mode dropped before the declared word count was written; held until the next download starts or reset.

Function
REQ-013 Storage: 2^ADDR_WIDTH x 32-bit array, written only by the download FSM.
REQ-014 Run mode (upg_mode=0, FSM IDLE or DONE): Instruction SHALL equal mem[fetch_addr sampled at the previous rising edge], a registered read with 1-cycle latency.
REQ-015 While upg_busy=1 or upg_mode=1, Instruction SHALL read 32'h0000_0000 (NOP).
REQ-016 FSM states: IDLE, HDR0, HDR1, COLLECT, WRITE, DONE.
REQ-017 IDLE or DONE with upg_mode=1 -> HDR0; entering HDR0 clears upg_done and upg_err, sets word pointer wp=0 and byte index bi=0.
REQ-018 HDR0: byte with valid -> count[7:0], go to HDR1. HDR1: byte with valid -> count[15:8], go to COLLECT.
REQ-019 Declared count N = {HDR1 byte, HDR0 byte}; N=0 or N>2^ADDR_WIDTH SHALL be treated as 2^ADDR_WIDTH.
REQ-020 COLLECT: each valid byte is placed little-endian (bi=0 -> bits[7:0] ... bi=3 -> bits[31:24]), bi increments; the 4th byte goes to WRITE.
REQ-021 WRITE (exactly one cycle): mem[wp] <= assembled word, wp <= wp+1, bi <= 0; if the written word was word N-1 -> DONE, else -> COLLECT.
REQ-022 A byte strobe arriving in the WRITE cycle SHALL be captured as byte 0 of the next word, not dropped.
REQ-023 wp SHALL never wrap: the write of word 2^ADDR_WIDTH-1 always terminates (-> DONE).
REQ-024 upg_mode falling in HDR0..COLLECT -> IDLE with upg_err=1 and no further writes; a byte strobe in that same cycle SHALL be ignored; a partial word SHALL NOT be written.
REQ-025 DONE: upg_done=1; stays in DONE until upg_mode returns 0 then 1 (rising edge starts a new download); upg_mode still 1 after completion SHALL NOT restart.
REQ-026 upg_rx_valid SHALL be ignored in IDLE and DONE.

Reset
REQ-027 On reset: FSM=IDLE, wp=0, bi=0, upg_busy=0, upg_done=0, upg_err=0, Instruction=32'h0.
REQ-028 Memory contents SHALL NOT be cleared by reset; reset in the middle of a download aborts it, and words already written remain.

Verification
REQ-029 Download N=2, bytes 02 00 | 20 08 00 05 | 3C 01 00 00 -> mem[0]=32'h0500_0820, mem[1]=32'h0000_013C, upg_done=1, upg_err=0.
REQ-030 Run mode after REQ-029, fetch_addr=1 -> Instruction=32'h0000_013C one cycle later; fetch_addr=0 -> 32'h0500_0820 one cycle later.
REQ-031 Header 00 00 (N=0) with ADDR_WIDTH=4 -> 16 words accepted, DONE after the 16th write, wp does not wrap.
REQ-032 Drop upg_mode after 6 data bytes of N=3 -> mem[0] written, mem[1] unchanged, upg_err=1, FSM IDLE.
REQ-033 Assert reset after 5 data bytes -> all outputs at reset values immediately, mem[0] retained, next download starts with wp=0.
REQ-034 Byte strobe in the WRITE cycle -> that byte lands in bits[7:0] of the next word.
